// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns spi_slave byte traffic into burst register writes/reads with address auto-increment.
// Defining SPI_REG_WPROT_EN adds the wp input, which blocks register writes while high.
module spi_reg_ctrl #(
  parameter int NREGS    = 16,
  parameter int AUTO_INC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       tx_wr,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
`ifdef SPI_REG_WPROT_EN
  input  logic       wp,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_FETCH = 3'd3,
    ST_LOAD  = 3'd4,
    ST_RDATA = 3'd5
  } state_t;

  localparam logic [7:0] NREGS_W  = 8'(NREGS);
  localparam logic [6:0] LAST_REG = 7'(NREGS - 1);

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  // Out-of-range addresses climb to 127 and the 7-bit add wraps them to 0.
  function automatic logic [6:0] adv_addr(input logic [6:0] a);
    logic [6:0] n;
    if (AUTO_INC == 0)                      n = a;
    else if (in_range(a) && a == LAST_REG) n = 7'd0;
    else                                    n = a + 7'd1;
    return n;
  endfunction

  logic       wp_s;
`ifdef SPI_REG_WPROT_EN
  assign wp_s = wp;
`else
  assign wp_s = 1'b0;
`endif

  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       ss_meta_r, ss_sync_r, ss_prev_r;
  logic       sclk_rise_s, ss_rise_s, ss_fall_s;
  logic [2:0] bit_cnt_r;
  logic       byte_done_r, ss_rise_r, ss_fall_r;
  state_t     state_r, state_nxt_s;
  logic       wr_adv_r, wr_adv_s;
  logic [7:0] tx_byte_s, wdata_s;
  logic [6:0] addr_s;
  logic       tx_wr_s, we_s, re_s, busy_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign ss_rise_s   = ss_sync_r & ~ss_prev_r;
  assign ss_fall_s   = ~ss_sync_r & ss_prev_r;

  // ss copies reset low so a select already held low at reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      ss_meta_r   <= 1'b0;
      ss_sync_r   <= 1'b0;
      ss_prev_r   <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      ss_meta_r   <= ss;
      ss_sync_r   <= ss_meta_r;
      ss_prev_r   <= ss_sync_r;
    end
  end

  // The ss_rise term keeps an 8th edge that coincides with deselect counted as a full byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r   <= 3'd0;
      byte_done_r <= 1'b0;
      ss_rise_r   <= 1'b0;
      ss_fall_r   <= 1'b0;
    end else begin
      ss_rise_r   <= ss_rise_s;
      ss_fall_r   <= ss_fall_s;
      byte_done_r <= sclk_rise_s & (~ss_sync_r | ss_rise_s) & (bit_cnt_r == 3'd7);
      if (ss_sync_r || (ss_fall_r && state_r == ST_IDLE)) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    if (ss_rise_r) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ss_fall_r ? ST_CMD : ST_IDLE;
        ST_CMD:   state_nxt_s = !byte_done_r ? ST_CMD : (rx_byte[7] ? ST_FETCH : ST_WDATA);
        ST_WDATA: state_nxt_s = ST_WDATA;
        ST_FETCH: state_nxt_s = ST_LOAD;
        ST_LOAD:  state_nxt_s = ST_RDATA;
        ST_RDATA: state_nxt_s = byte_done_r ? ST_FETCH : ST_RDATA;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // A write's address advance waits one cycle so reg_addr stays valid alongside reg_we.
  always_comb begin
    tx_byte_s = tx_byte;
    tx_wr_s   = 1'b0;
    addr_s    = wr_adv_r ? adv_addr(reg_addr) : reg_addr;
    wdata_s   = reg_wdata;
    we_s      = 1'b0;
    wr_adv_s  = 1'b0;
    case (state_r)
      ST_CMD: begin
        addr_s = byte_done_r ? rx_byte[6:0] : reg_addr;
      end
      ST_WDATA: begin
        if (byte_done_r) begin
          wdata_s  = rx_byte;
          we_s     = in_range(reg_addr) & ~wp_s;
          wr_adv_s = 1'b1;
        end else begin
          wdata_s  = reg_wdata;
        end
      end
      ST_LOAD: begin
        if (state_nxt_s == ST_RDATA) begin
          tx_byte_s = in_range(reg_addr) ? reg_rdata : 8'h00;
          tx_wr_s   = 1'b1;
        end else begin
          tx_byte_s = tx_byte;
        end
      end
      ST_RDATA: begin
        addr_s = byte_done_r ? adv_addr(reg_addr) : reg_addr;
      end
      default: begin
        tx_wr_s = 1'b0;
      end
    endcase
    re_s   = (state_nxt_s == ST_FETCH) && in_range(addr_s);
    busy_s = (state_nxt_s != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte   <= 8'h00;
      tx_wr     <= 1'b0;
      reg_addr  <= 7'd0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      wr_adv_r  <= 1'b0;
    end else begin
      tx_byte   <= tx_byte_s;
      tx_wr     <= tx_wr_s;
      reg_addr  <= addr_s;
      reg_wdata <= wdata_s;
      reg_we    <= we_s;
      reg_re    <= re_s;
      busy      <= busy_s;
      wr_adv_r  <= wr_adv_s;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: SPI master driver, register bank, table vectors, corner sequences, random bursts.
module tb_spi_reg_ctrl;
  localparam int NREGS    = 16;
  localparam int AUTO_INC = 1;
  localparam int HALF     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_wr;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
`ifdef SPI_REG_WPROT_EN
  logic       wp = 1'b0;
`endif

  spi_reg_ctrl #(.NREGS(NREGS), .AUTO_INC(AUTO_INC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .tx_wr(tx_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
`ifdef SPI_REG_WPROT_EN
    .wp(wp),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bank [0:NREGS-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (reg_we && int'(reg_addr) < NREGS) bank[int'(reg_addr)] <= reg_wdata;
    if (reg_re) reg_rdata <= (int'(reg_addr) < NREGS) ? bank[int'(reg_addr)] : 8'hEE;
  end

  int          last_rise = 0;
  logic [14:0] obs_we_q[$];
  logic [6:0]  obs_re_q[$];
  logic [7:0]  obs_tx_q[$];
  int          lat_we_q[$], lat_re_q[$], lat_tx_q[$];
  int          width_err = 0;
  logic        prev_we = 1'b0, prev_re = 1'b0, prev_tx = 1'b0;

  always @(negedge clk) begin
    if (reg_we) begin obs_we_q.push_back({reg_addr, reg_wdata}); lat_we_q.push_back(cyc - last_rise); end
    if (reg_re) begin obs_re_q.push_back(reg_addr); lat_re_q.push_back(cyc - last_rise); end
    if (tx_wr)  begin obs_tx_q.push_back(tx_byte); lat_tx_q.push_back(cyc - last_rise); end
    if ((reg_we && prev_we) || (reg_re && prev_re) || (tx_wr && prev_tx)) width_err <= width_err + 1;
    prev_we <= reg_we;
    prev_re <= reg_re;
    prev_tx <= tx_wr;
  end

  // Reference model: memory image plus expected strobe streams for one transaction.
  logic [7:0]  model_mem [0:NREGS-1] = '{default: 8'h00};
  logic [7:0]  txb [0:7];
  logic [14:0] exp_we_q[$];
  logic [6:0]  exp_re_q[$];
  logic [7:0]  exp_tx_q[$];

  function automatic logic [6:0] model_next(input logic [6:0] a);
    int n;
    if (AUTO_INC == 0) return a;
    if (int'(a) < NREGS) n = (int'(a) + 1) % NREGS;
    else                 n = (int'(a) + 1) % 128;
    return 7'(n);
  endfunction

  task automatic model_txn(input int n);
    logic [6:0] a;
    a = txb[0][6:0];
    exp_we_q.delete(); exp_re_q.delete(); exp_tx_q.delete();
    if (txb[0][7]) begin
      for (int j = 0; j < n; j++) begin
        if (int'(a) < NREGS) begin
          exp_re_q.push_back(a);
          exp_tx_q.push_back(model_mem[int'(a)]);
        end else begin
          exp_tx_q.push_back(8'h00);
        end
        a = model_next(a);
      end
    end else begin
      for (int i = 1; i < n; i++) begin
        if (int'(a) < NREGS) begin
          exp_we_q.push_back({a, txb[i]});
          model_mem[int'(a)] = txb[i];
        end
        a = model_next(a);
      end
    end
  endtask

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic clear_obs();
    obs_we_q.delete(); obs_re_q.delete(); obs_tx_q.delete();
    lat_we_q.delete(); lat_re_q.delete(); lat_tx_q.delete();
  endtask

  task automatic compare_obs(input string tag);
    check({tag, " we count"}, obs_we_q.size(), exp_we_q.size());
    for (int i = 0; i < obs_we_q.size() && i < exp_we_q.size(); i++)
      check({tag, " we addr/data"}, obs_we_q[i], exp_we_q[i]);
    check({tag, " re count"}, obs_re_q.size(), exp_re_q.size());
    for (int i = 0; i < obs_re_q.size() && i < exp_re_q.size(); i++)
      check({tag, " re addr"}, obs_re_q[i], exp_re_q[i]);
    check({tag, " tx count"}, obs_tx_q.size(), exp_tx_q.size());
    for (int i = 0; i < obs_tx_q.size() && i < exp_tx_q.size(); i++)
      check({tag, " tx data"}, obs_tx_q[i], exp_tx_q[i]);
    foreach (lat_we_q[i]) check({tag, " we latency"}, lat_we_q[i], 4);
    foreach (lat_re_q[i]) check({tag, " re latency"}, lat_re_q[i], 4);
    foreach (lat_tx_q[i]) check({tag, " tx_wr latency"}, lat_tx_q[i], 6);
  endtask

  // SPI mode 0 master; the slave's rx_buffer updates on the 8th rising edge.
  task automatic send_bits(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      last_rise = cyc;
      if (i == 7) rx_byte = b;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic start_txn();
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_txn();
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic run_txn(input int n, input string tag);
    model_txn(n);
    clear_obs();
    start_txn();
    check({tag, " busy active"}, busy, 1);
    for (int i = 0; i < n; i++) send_bits(8, txb[i]);
    end_txn();
    check({tag, " busy idle"}, busy, 0);
    if (txb[0][7] && exp_tx_q.size() > 0)
      check({tag, " tx_byte held"}, tx_byte, exp_tx_q[exp_tx_q.size()-1]);
    compare_obs(tag);
  endtask

  typedef struct {
    logic [7:0] cmd, d0, d1;
    int         we_n;
    logic [6:0] wa0;
    logic [7:0] wd0;
    logic [6:0] wa1;
    logic [7:0] wd1;
    int         re_n;
    int         tx_n;
    logic [7:0] tx0, tx1;
  } vec_t;

  vec_t vecs [0:8];

  initial begin : main
    int         rn;
    logic [6:0] ra;

    vecs[0] = '{8'h03, 8'hAA, 8'hBB, 2, 7'd3,  8'hAA, 7'd4, 8'hBB, 0, 0, 8'h00, 8'h00};
    vecs[1] = '{8'h0F, 8'h5A, 8'hC3, 2, 7'd15, 8'h5A, 7'd0, 8'hC3, 0, 0, 8'h00, 8'h00};
    vecs[2] = '{8'h05, 8'h11, 8'h22, 2, 7'd5,  8'h11, 7'd6, 8'h22, 0, 0, 8'h00, 8'h00};
    vecs[3] = '{8'h85, 8'h00, 8'h00, 0, 7'd0,  8'h00, 7'd0, 8'h00, 3, 3, 8'h11, 8'h22};
    vecs[4] = '{8'h8F, 8'h00, 8'h00, 0, 7'd0,  8'h00, 7'd0, 8'h00, 3, 3, 8'h5A, 8'hC3};
    vecs[5] = '{8'hA0, 8'h00, 8'h00, 0, 7'd0,  8'h00, 7'd0, 8'h00, 0, 3, 8'h00, 8'h00};
    vecs[6] = '{8'h20, 8'h11, 8'h22, 0, 7'd0,  8'h00, 7'd0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[7] = '{8'h7F, 8'h99, 8'h77, 1, 7'd0,  8'h77, 7'd0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[8] = '{8'h80, 8'h00, 8'h00, 0, 7'd0,  8'h00, 7'd0, 8'h00, 3, 3, 8'h77, 8'h00};

    repeat (4) @(negedge clk);
    check("reset tx_byte", tx_byte, 8'h00);
    check("reset tx_wr", tx_wr, 0);
    check("reset reg_addr", reg_addr, 7'd0);
    check("reset reg_wdata", reg_wdata, 8'h00);
    check("reset reg_we", reg_we, 0);
    check("reset reg_re", reg_re, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      txb[0] = vecs[v].cmd; txb[1] = vecs[v].d0; txb[2] = vecs[v].d1;
      run_txn(3, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table we count", v), obs_we_q.size(), vecs[v].we_n);
      if (vecs[v].we_n > 0 && obs_we_q.size() > 0)
        check($sformatf("vec%0d table we0", v), obs_we_q[0], {vecs[v].wa0, vecs[v].wd0});
      if (vecs[v].we_n > 1 && obs_we_q.size() > 1)
        check($sformatf("vec%0d table we1", v), obs_we_q[1], {vecs[v].wa1, vecs[v].wd1});
      check($sformatf("vec%0d table re count", v), obs_re_q.size(), vecs[v].re_n);
      check($sformatf("vec%0d table tx count", v), obs_tx_q.size(), vecs[v].tx_n);
      if (vecs[v].tx_n > 0 && obs_tx_q.size() > 1) begin
        check($sformatf("vec%0d table tx0", v), obs_tx_q[0], vecs[v].tx0);
        check($sformatf("vec%0d table tx1", v), obs_tx_q[1], vecs[v].tx1);
      end
    end

    // Abort after half a data byte: no write, back to idle.
    clear_obs();
    start_txn();
    send_bits(8, 8'h02);
    send_bits(4, 8'h00);
    end_txn();
    check("abort no we", obs_we_q.size(), 0);
    check("abort busy", busy, 0);
    txb[0] = 8'h02; txb[1] = 8'h44;
    run_txn(2, "after abort");

    // 8th sclk edge and deselect on the same raw instant: write must still land.
    txb[0] = 8'h09; txb[1] = 8'h3C;
    model_txn(2);
    clear_obs();
    start_txn();
    send_bits(8, 8'h09);
    send_bits(7, 8'h00);
    repeat (HALF) @(negedge clk);
    sclk = 1'b1; ss = 1'b1; rx_byte = 8'h3C; last_rise = cyc;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (16) @(negedge clk);
    check("coincident busy", busy, 0);
    compare_obs("coincident");

    // Reset in the middle of a read burst, then keep clocking the stale transaction.
    clear_obs();
    start_txn();
    send_bits(8, 8'h85);
    send_bits(3, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreset tx_byte", tx_byte, 8'h00);
    check("midreset tx_wr", tx_wr, 0);
    check("midreset reg_addr", reg_addr, 7'd0);
    check("midreset reg_wdata", reg_wdata, 8'h00);
    check("midreset reg_we", reg_we, 0);
    check("midreset reg_re", reg_re, 0);
    check("midreset busy", busy, 0);
    clear_obs();
    send_bits(5, 8'h00);
    send_bits(8, 8'h00);
    send_bits(8, 8'h00);
    check("stale no we", obs_we_q.size(), 0);
    check("stale no re", obs_re_q.size(), 0);
    check("stale no tx_wr", obs_tx_q.size(), 0);
    check("stale busy", busy, 0);
    end_txn();
    txb[0] = 8'h85; txb[1] = 8'h00;
    run_txn(2, "fresh read");

`ifdef SPI_REG_WPROT_EN
    clear_obs();
    start_txn();
    wp = 1'b1;
    send_bits(8, 8'h02);
    send_bits(8, 8'h61);
    wp = 1'b0;
    send_bits(8, 8'h62);
    end_txn();
    check("wp we count", obs_we_q.size(), 1);
    if (obs_we_q.size() > 0) check("wp we addr/data", obs_we_q[0], {7'd3, 8'h62});
    model_mem[3] = 8'h62;
    txb[0] = 8'h02; txb[1] = 8'h63;
    run_txn(2, "wp clear");
`endif

    for (int t = 0; t < 30; t++) begin
      rn = $urandom_range(2, 5);
      if ($urandom_range(0, 3) == 0) ra = 7'($urandom_range(120, 127));
      else                           ra = 7'($urandom_range(0, NREGS + 3));
      txb[0] = {1'($urandom_range(0, 1)), ra};
      for (int i = 1; i < rn; i++) txb[i] = 8'($urandom);
      run_txn(rn, $sformatf("rand%0d", t));
    end

    check("strobe widths", width_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
